menu_button_conditioner: RTL and testbench
==========================================

// Module: menu_button_conditioner
// PURPOSE
// - Front end of the editor menu: converts the five raw push-buttons into clean,
//   single-cycle navigation pulses for the menu controller.
// - Per button: synchronise, debounce and detect the press edge. Arrow buttons also
//   auto-repeat while held.
// - Output pulses are serialised: one per pulse slot, with a guaranteed idle gap, so the
//   controller's OR-of-buttons event edge fires once per event.
// PARAMETERS
// DEBOUNCE_CYCLES  1_000_000   cycles input must be stable to change state (10 ms @100 MHz)
// REPEAT_DELAY     50_000_000  cycles from press pulse to first repeat (500 ms)
// REPEAT_RATE      15_000_000  cycles between subsequent repeats (150 ms)
// MIN_GAP          4           minimum cycles from one pulse's rise to the next pulse's rise (>=2)
// CNT_W            27          counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY)
// PORTS
// clk               in   1  system clock, 100 MHz
// reset             in   1  asynchronous, active-low reset
// boton_arriba_in   in   1  raw button, asynchronous, active-high
// boton_abajo_in    in   1  raw button
// boton_izq_in      in   1  raw button
// boton_der_in      in   1  raw button
// boton_elige_in    in   1  raw button (select)
// boton_arriba_out  out  1  one-cycle press/repeat pulse
// boton_abajo_out   out  1  one-cycle press/repeat pulse
// boton_izq_out     out  1  one-cycle press/repeat pulse
// boton_der_out     out  1  one-cycle press/repeat pulse
// boton_elige_out   out  1  one-cycle press pulse (never repeats)
// BEHAVIOUR
// - Reset (reset=0, async): all outputs 0, synchronisers 0, debounced states 0 (released).
//   All counters, pending flags and repeat timers are cleared.
// - Sync: each raw input passes through a 2-flop synchroniser. There is no other path from raw inputs.
// - Debounce: a per-button counter runs while the synced value differs from the debounced state.
//   - Any cycle where they match clears the counter.
//   - When the counter reaches DEBOUNCE_CYCLES, the debounced state takes the synced value and the counter clears.
// - Press event: a debounced 0->1 transition sets that button's pending flag.
//   - Release (1->0) produces no event.
//   - An event on a button whose flag is already set merges; it is not counted twice.
// - Auto-repeat, arrows only: while debounced=1, a repeat timer starts at the press event.
//   - First repeat event is REPEAT_DELAY cycles after the press event.
//   - Later repeats follow every REPEAT_RATE cycles.
//   - Release stops the timer immediately. Any pending flag remains and is still issued.
// - Issue arbiter (2-state FSM):
//   - IDLE: if any flag is set, assert exactly one output for 1 cycle and clear its flag,
//     then enter GAP. Priority: elige > arriba > abajo > izq > der.
//   - GAP: hold all outputs 0 for MIN_GAP-1 cycles, then return to IDLE.
// - Latency: an isolated press stable from raw edge cycle 0 gives a pulse in cycle DEBOUNCE_CYCLES+3.
//   Breakdown: 2 sync + DEBOUNCE_CYCLES + 1 register.
// - Invariants:
//   - At most one output is high in any cycle.
//   - Every output pulse is exactly 1 cycle wide.
//   - No event is lost except by merge.
// - Repeat timing is measured from the event, not from issue. Arbitration delay does not shift the repeat schedule.
// - Button held through reset deassertion: it is treated as a new press and produces one pulse
//   DEBOUNCE_CYCLES+3 cycles after reset rises.
// - Reset asserted mid-hold or mid-GAP: outputs drop to 0 asynchronously and all in-flight events are discarded.
// STRUCTURE
// - Shared package/include: button index constants (IDX_ARRIBA=0 .. IDX_ELIGE=4), the priority order,
//   and the repeat-enable mask 5'b01111.
// - One sub-module, menu_pb_debounce, instantiated 5x: synchroniser, debounce counter, press edge,
//   and an optional repeat timer (parameter REPEAT_EN).
// - Top level: pending flags plus the IDLE/GAP arbiter.
// TESTING (DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_RATE=16, MIN_GAP=4)
// - Reset low with all inputs toggling -> all outputs 0 throughout; first pulse no earlier than 11 cycles after reset rises.
// - arriba_in toggled every 3 cycles for 30 cycles, then held 1 from cycle T
//   -> exactly one boton_arriba_out pulse, at T+11. No pulse during bouncing.
// - der_in held 1 for 100 cycles from T -> pulses at T+11, +51, +67, +83, +99. Release at T+100 -> no further pulses.
// - elige_in held 1 for 100 cycles from T -> exactly one boton_elige_out pulse at T+11.
// - izq_in and elige_in rise in the same cycle T -> elige pulse at T+11, izq pulse at T+15. Never both high together.
// - abajo held; reset pulsed low at T+20 for 3 cycles -> output 0 at once.
//   With abajo still held, one pulse at (reset rise)+11. Repeat then restarts from that event.

Source files
------------

// File: rtl/menu_button_conditioner_pkg.sv
// Shared button indices, issue priority and repeat mask for the menu button front end.
package menu_button_conditioner_pkg;

  localparam int NUM_BTN    = 5;
  localparam int IDX_ARRIBA = 0;
  localparam int IDX_ABAJO  = 1;
  localparam int IDX_IZQ    = 2;
  localparam int IDX_DER    = 3;
  localparam int IDX_ELIGE  = 4;

  // Arrows auto-repeat; select never does.
  localparam logic [NUM_BTN-1:0] REPEAT_MASK = 5'b01111;

  // Highest priority first.
  localparam int PRIO_ORDER [NUM_BTN] = '{IDX_ELIGE, IDX_ARRIBA, IDX_ABAJO, IDX_IZQ, IDX_DER};

  typedef enum logic {ARB_IDLE, ARB_GAP} arb_state_e;

  // One-hot grant of the highest-priority requester; walks lowest to highest so the last hit wins.
  function automatic logic [NUM_BTN-1:0] prio_pick(input logic [NUM_BTN-1:0] req);
    logic [NUM_BTN-1:0] g;
    g = '0;
    for (int i = NUM_BTN-1; i >= 0; i--) begin
      if (req[PRIO_ORDER[i]]) begin
        g = '0;
        g[PRIO_ORDER[i]] = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/menu_button_conditioner_pb.sv
// Per-button conditioner: 2-flop sync, stability-count debounce, press edge and optional auto-repeat.
module menu_pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 15_000_000,
  parameter int CNT_W           = 27,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic event_o
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

  logic [1:0]       sync_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_act_q, rpt_act_d;
  logic             rpt_first_q, rpt_first_d;
  logic             press, fire;

  always_comb begin
    deb_d       = deb_q;
    cnt_d       = '0;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_act_d   = rpt_act_q;
    rpt_first_d = rpt_first_q;
    fire        = 1'b0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == DB_LAST) deb_d = sync_q[1];
      else                  cnt_d = cnt_q + 1'b1;
    end
    press = deb_d & ~deb_q;
    if (REPEAT_EN) begin
      // Timer is anchored to the event itself, so issue delay never skews the schedule.
      if (press) begin
        rpt_act_d   = 1'b1;
        rpt_first_d = 1'b1;
        rpt_cnt_d   = '0;
      end else if (!deb_d) begin
        rpt_act_d = 1'b0;
        rpt_cnt_d = '0;
      end else if (rpt_act_q) begin
        if (rpt_cnt_q == (rpt_first_q ? DLY_LAST : RATE_LAST)) begin
          fire        = 1'b1;
          rpt_first_d = 1'b0;
          rpt_cnt_d   = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
    end
    event_o = press | fire;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= '0;
      deb_q       <= 1'b0;
      cnt_q       <= '0;
      rpt_cnt_q   <= '0;
      rpt_act_q   <= 1'b0;
      rpt_first_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], btn_i};
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_act_q   <= rpt_act_d;
      rpt_first_q <= rpt_first_d;
    end
  end

endmodule

// File: rtl/menu_button_conditioner.sv
// Five conditioned buttons feeding pending flags and an IDLE/GAP arbiter that serialises output pulses.
module menu_button_conditioner
  import menu_button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 15_000_000,
  parameter int MIN_GAP         = 4,
  parameter int CNT_W           = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic boton_arriba_in,
  input  logic boton_abajo_in,
  input  logic boton_izq_in,
  input  logic boton_der_in,
  input  logic boton_elige_in,
  output logic boton_arriba_out,
  output logic boton_abajo_out,
  output logic boton_izq_out,
  output logic boton_der_out,
  output logic boton_elige_out
);

  localparam int               GAP_W    = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP - 2);

  logic [NUM_BTN-1:0] raw, ev;
  logic [NUM_BTN-1:0] pend_q, pend_d, out_q, out_d, grant;
  logic [GAP_W-1:0]   gap_q, gap_d;
  arb_state_e         state_q, state_d;

  assign raw[IDX_ARRIBA] = boton_arriba_in;
  assign raw[IDX_ABAJO]  = boton_abajo_in;
  assign raw[IDX_IZQ]    = boton_izq_in;
  assign raw[IDX_DER]    = boton_der_in;
  assign raw[IDX_ELIGE]  = boton_elige_in;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    menu_pb_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .CNT_W          (CNT_W),
      .REPEAT_EN      (REPEAT_MASK[g])
    ) u_pb (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (raw[g]),
      .event_o(ev[g])
    );
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    out_d   = '0;
    grant   = prio_pick(pend_q);
    case (state_q)
      ARB_IDLE: if (|pend_q) begin
        out_d   = grant;
        state_d = ARB_GAP;
        gap_d   = '0;
      end
      ARB_GAP: begin
        if (gap_q == GAP_LAST) state_d = ARB_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = ARB_IDLE;
    endcase
    // A new event arriving as its flag is issued re-arms the flag rather than being lost.
    pend_d = (pend_q & ~out_d) | ev;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      gap_q   <= '0;
      pend_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
    end
  end

  assign boton_arriba_out = out_q[IDX_ARRIBA];
  assign boton_abajo_out  = out_q[IDX_ABAJO];
  assign boton_izq_out    = out_q[IDX_IZQ];
  assign boton_der_out    = out_q[IDX_DER];
  assign boton_elige_out  = out_q[IDX_ELIGE];

endmodule

// File: tb/tb_menu_button_conditioner.sv
// Directed bench: every observed output pulse is logged and compared against hand-computed schedules.
module tb_menu_button_conditioner;
  import menu_button_conditioner_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] btn = '0;
  logic [4:0] outs;
  int cyc = 0, total = 0, bad = 0, multi = 0;
  int T, R;
  int ev_c[$], ev_i[$], ex_c[$], ex_i[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  menu_button_conditioner #(
    .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(40), .REPEAT_RATE(16), .MIN_GAP(4), .CNT_W(27)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .boton_arriba_in (btn[IDX_ARRIBA]),
    .boton_abajo_in  (btn[IDX_ABAJO]),
    .boton_izq_in    (btn[IDX_IZQ]),
    .boton_der_in    (btn[IDX_DER]),
    .boton_elige_in  (btn[IDX_ELIGE]),
    .boton_arriba_out(outs[IDX_ARRIBA]),
    .boton_abajo_out (outs[IDX_ABAJO]),
    .boton_izq_out   (outs[IDX_IZQ]),
    .boton_der_out   (outs[IDX_DER]),
    .boton_elige_out (outs[IDX_ELIGE])
  );

  always @(negedge clk) begin
    if ($countones(outs) > 1) multi++;
    for (int i = 0; i < 5; i++)
      if (outs[i]) begin
        ev_c.push_back(cyc);
        ev_i.push_back(i);
      end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int c, input int idx);
    ex_c.push_back(c);
    ex_i.push_back(idx);
  endtask

  task automatic check_events(input string tag);
    int n;
    chk($sformatf("%s_count", tag), ev_c.size(), ex_c.size());
    n = (ev_c.size() < ex_c.size()) ? ev_c.size() : ex_c.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_cyc%0d", tag, i), ev_c[i], ex_c[i]);
      chk($sformatf("%s_btn%0d", tag, i), ev_i[i], ex_i[i]);
    end
    ev_c.delete(); ev_i.delete(); ex_c.delete(); ex_i.delete();
  endtask

  initial begin
    // Reset held with inputs thrashing: nothing may come out.
    tick(1);
    @(negedge clk);
    chk("reset_outs", int'(outs), 0);
    tick(1);
    for (int i = 0; i < 20; i++) begin
      btn = 5'($urandom);
      tick(1);
    end
    btn = '0;
    reset = 1'b1;
    tick(40);
    check_events("reset");

    // Bouncing arriba, then a clean hold.
    for (int i = 0; i < 10; i++) begin
      btn[IDX_ARRIBA] = (i % 2 == 0);
      tick(3);
    end
    T = cyc;
    btn[IDX_ARRIBA] = 1'b1;
    tick(20);
    btn = '0;
    tick(50);
    expect_ev(T + 11, IDX_ARRIBA);
    check_events("bounce");

    // der held: press plus auto-repeat, nothing after release.
    T = cyc;
    btn[IDX_DER] = 1'b1;
    tick(100);
    btn = '0;
    tick(40);
    expect_ev(T + 11, IDX_DER);
    expect_ev(T + 51, IDX_DER);
    expect_ev(T + 67, IDX_DER);
    expect_ev(T + 83, IDX_DER);
    expect_ev(T + 99, IDX_DER);
    check_events("repeat");

    // elige held: never repeats.
    T = cyc;
    btn[IDX_ELIGE] = 1'b1;
    tick(100);
    btn = '0;
    tick(30);
    expect_ev(T + 11, IDX_ELIGE);
    check_events("select");

    // Simultaneous izq + elige: priority then gap.
    T = cyc;
    btn[IDX_IZQ] = 1'b1;
    btn[IDX_ELIGE] = 1'b1;
    tick(20);
    btn = '0;
    tick(30);
    expect_ev(T + 11, IDX_ELIGE);
    expect_ev(T + 15, IDX_IZQ);
    check_events("prio");

    // abajo held across a reset pulse: fresh press after reset, repeat restarts.
    T = cyc;
    btn[IDX_ABAJO] = 1'b1;
    tick(20);
    reset = 1'b0;
    #1;
    chk("reset_async", int'(outs), 0);
    tick(3);
    reset = 1'b1;
    R = cyc;
    tick(52);
    btn = '0;
    tick(40);
    expect_ev(T + 11, IDX_ABAJO);
    expect_ev(R + 11, IDX_ABAJO);
    expect_ev(R + 51, IDX_ABAJO);
    check_events("held_rst");

    chk("onehot", multi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
